load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of ACCESS cycles without ack before fault; 0 disables the timeout.
REQ-002 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_valid  in  1  request present; sampled only while o_ready=1.
REQ-005 o_ready  out  1  unit can accept a request.
REQ-006 i_load, i_store  in  1 each  operation kind; store SHALL win if both are set.
REQ-007 i_funct3  in  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 i_addr  in  32  effective address, taken from the ALU result.
REQ-009 i_wdata  in  32  store data (rs2).
REQ-010 o_mem_req, o_mem_we  out  1 each  memory request and write enable.
REQ-011 o_mem_addr  out  32  word address (bits [1:0] = 0).
REQ-012 o_mem_wdata  out  32  lane-replicated store data.
REQ-013 o_mem_mask  out  4  byte enables.
REQ-014 i_mem_ack  in  1  memory completion; i_mem_rdata  in  32  valid with ack.
REQ-015 o_done  out  1  one-cycle completion pulse; o_rdata  out  32  formatted load data.
REQ-016 o_fault  out  1  with o_done: illegal funct3, misaligned access, or timeout.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP; o_ready=1 only in IDLE.
REQ-018 In IDLE, i_valid with i_load or i_store SHALL latch addr, wdata, funct3, and kind; i_valid with neither SHALL be ignored.
REQ-019 A latched request that is legal SHALL move to ACCESS; an illegal one (funct3 011/110/111, or 1xx on a store) SHALL move to RESP with o_fault=1 and no memory request.
REQ-020 In ACCESS, o_mem_req SHALL stay at 1 and address, data, mask, and we SHALL stay stable until i_mem_ack.
REQ-021 i_mem_ack seen in ACCESS SHALL go to RESP; o_done SHALL be 1 for exactly the RESP cycle; RESP SHALL then go to IDLE. Minimum latency is 3 cycles from accept to o_done.
REQ-022 i_mem_ack outside ACCESS SHALL be ignored.
REQ-023 Store mask: B = 1<<addr[1:0]; H = 0011 when addr[1]=0, else 1100; W = 1111. Data is replicated across all lanes.
REQ-024 Loads SHALL select the lane by addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through. The result is captured into o_rdata on ack.
REQ-025 o_rdata SHALL hold its value until the next load completes; store and fault completions SHALL leave it unchanged.
REQ-026 A cycle counter SHALL run in ACCESS. When it reaches TIMEOUT_CYCLES (nonzero) with no ack, the unit SHALL drop o_mem_req and go to RESP with o_fault=1. An ack in the same cycle as the timeout SHALL win, with no fault.

Reset
REQ-027 i_rst SHALL force IDLE, o_mem_req=0, o_done=0, o_fault=0, o_rdata=0, and counter=0 at the next edge, including in the middle of ACCESS.
REQ-028 An i_mem_ack arriving after a mid-ACCESS reset SHALL produce no o_done.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined, H with addr[0]=1 and W with addr[1:0]!=0 SHALL be faulted in RESP with no memory request.
REQ-030 With LSU_MISALIGN_TRAP_EN undefined, misaligned low bits SHALL be ignored (H uses addr[1]; W ignores [1:0]), the access SHALL proceed, and o_fault SHALL never be set for misalignment.

Structure
REQ-031 Package lsu_pkg SHALL hold the funct3 width constants, the FSM state encoding, and the default TIMEOUT_CYCLES.
REQ-032 The lane formatting (store mask/replication and load extract/extend) SHALL be a combinational sub-module, lsu_lane_align.

Verification
REQ-033 SB: addr 0x1003, wdata 0xAB -> mask 1000, mem_wdata 0xABABABAB, mem_addr 0x1000, o_done 3 cycles after accept with ack 1 cycle after req.
REQ-034 LB: addr 0x2001, rdata 0x0000_8000 -> o_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-035 LH: addr 0x2002, rdata 0x8001_0000 -> 0xFFFF8001. LW: addr 0x2000 -> rdata unchanged.
REQ-036 SW at 0x3002 with the macro defined -> no o_mem_req and o_done+o_fault. Without the macro -> mask 1111 at 0x3000.
REQ-037 TIMEOUT_CYCLES=4, no ack -> o_mem_req drops after 4 ACCESS cycles, then o_done+o_fault; ack on the 4th cycle -> normal completion.
REQ-038 i_rst on the 2nd ACCESS cycle, then ack -> o_mem_req low next edge, o_ready=1, no o_done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 width codes, FSM encoding,
// default timeout, and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] carries the access size, funct3[2] selects zero-extension.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (is_store && f3[2]);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == SZ_H) && lo[0]) || ((f3[1:0] == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane formatting: store byte enables and lane replication,
// load lane extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    byte_sel = i_rdata[7:0];
      2'd1:    byte_sel = i_rdata[15:8];
      2'd2:    byte_sel = i_rdata[23:16];
      default: byte_sel = i_rdata[31:24];
    endcase
    half_sel = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    sext     = ~i_funct3[2];
  end

  always_comb begin
    o_mask  = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_funct3[1:0])
      SZ_B: begin
        o_mask  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        // Halfword lane comes from addr[1] only; addr[0] is dropped here.
        o_mask  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{sext & half_sel[15]}}, half_sel};
      end
      default: begin
        o_mask  = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit: IDLE -> ACCESS -> RESP with access timeout.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned H/W accesses instead of issuing them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request transfers on a rising edge where i_valid && o_ready and
  // at least one of i_load/i_store is set; the memory side transfers on the edge
  // where o_mem_req && i_mem_ack, with request fields held stable until then.

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req_misalign;
  logic        req_bad;
  logic        timeout_hit;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misalign = f3_misaligned(i_funct3, i_addr[1:0]);
`else
  assign req_misalign = 1'b0;
`endif

  assign req_bad     = f3_illegal(i_funct3, i_store) || req_misalign;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_lane_align u_lane_align (
    .i_funct3  (funct3_q),
    .i_addr_lo (addr_q[1:0]),
    .i_wdata   (wdata_q),
    .i_rdata   (i_mem_rdata),
    .o_mask    (lane_mask),
    .o_wdata   (lane_wdata),
    .o_rdata   (lane_rdata)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    cnt_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && (i_load || i_store)) begin
          addr_d   = i_addr;
          wdata_d  = i_wdata;
          funct3_d = i_funct3;
          store_d  = i_store;
          fault_d  = req_bad;
          state_d  = req_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Ack is checked first so an ack on the timeout cycle completes cleanly.
        if (i_mem_ack) begin
          state_d = ST_RESP;
          fault_d = 1'b0;
          if (!store_q) rdata_d = lane_rdata;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_mem_req   = (state_q == ST_ACCESS);
  assign o_mem_we    = (state_q == ST_ACCESS) && store_q;
  assign o_mem_addr  = {addr_q[31:2], 2'b00};
  assign o_mem_wdata = lane_wdata;
  assign o_mem_mask  = lane_mask;
  assign o_done      = (state_q == ST_RESP);
  assign o_fault     = (state_q == ST_RESP) && fault_q;
  assign o_rdata     = rdata_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam int T = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_load;
  logic        i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_load      (i_load),
    .i_store     (i_store),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_mask  (o_mem_mask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_fault     (o_fault),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic model_fault(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % nbytes_of(f3)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    int off;
    n   = nbytes_of(f3);
    off = int'(addr % 4) & (4 - n);
    return 32'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (nbytes_of(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    int n;
    int off;
    logic [31:0] v;
    n   = nbytes_of(f3);
    off = int'(addr % 4) & (4 - n);
    v   = rd >> (8 * off);
    if (n == 4) return v;
    v = v % (32'd1 << (8 * n));
    if (f3 < 3'd4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issues one request; the memory acks in ACCESS cycle ack_at (0 = first cycle).
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_at);
    logic exp_fault;
    logic timed_out;
    logic done_k;
    check_eq("ready_before", 32'(o_ready), 32'd1);
    i_valid  = 1'b1;
    i_load   = ld;
    i_store  = st;
    i_funct3 = f3;
    i_addr   = addr;
    i_wdata  = wd;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_load  = 1'b0;
    i_store = 1'b0;
    i_addr  = $urandom;
    i_wdata = $urandom;
    if (!ld && !st) begin
      check_eq("noop_ready", 32'(o_ready), 32'd1);
      check_eq("noop_req", 32'(o_mem_req), 32'd0);
      check_eq("noop_done", 32'(o_done), 32'd0);
      return;
    end
    exp_fault = model_fault(st, f3, addr);
    if (exp_fault) begin
      check_eq("bad_req", 32'(o_mem_req), 32'd0);
      check_eq("bad_done", 32'(o_done), 32'd1);
      check_eq("bad_fault", 32'(o_fault), 32'd1);
      check_eq("bad_rdata", o_rdata, last_rdata);
    end else begin
      for (int k = 0; k < T; k++) begin
        check_eq("acc_req", 32'(o_mem_req), 32'd1);
        check_eq("acc_ready", 32'(o_ready), 32'd0);
        check_eq("acc_we", 32'(o_mem_we), 32'(st));
        check_eq("acc_addr", o_mem_addr, addr & 32'hFFFF_FFFC);
        if (st) begin
          check_eq("acc_mask", 32'(o_mem_mask), model_mask(f3, addr));
          check_eq("acc_wdata", o_mem_wdata, model_wdata(f3, wd));
        end
        check_eq("acc_done", 32'(o_done), 32'd0);
        done_k = (k == ack_at) || (k == T - 1);
        if (k == ack_at) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = rd;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_mem_ack   = 1'b0;
        i_mem_rdata = $urandom;
        if (done_k) break;
      end
      timed_out = (ack_at > T - 1);
      if (!timed_out && !st) last_rdata = model_load(f3, addr, rd);
      check_eq("resp_done", 32'(o_done), 32'd1);
      check_eq("resp_fault", 32'(o_fault), 32'(timed_out));
      check_eq("resp_req", 32'(o_mem_req), 32'd0);
      check_eq("resp_rdata", o_rdata, last_rdata);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check_eq("done_pulse", 32'(o_done), 32'd0);
    check_eq("rdata_hold", o_rdata, last_rdata);
  endtask

  task automatic stray_ack(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      i_mem_ack   = 1'b1;
      i_mem_rdata = $urandom;
      @(posedge i_clk);
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      check_eq("stray_done", 32'(o_done), 32'd0);
      check_eq("stray_ready", 32'(o_ready), 32'd1);
      check_eq("stray_rdata", o_rdata, last_rdata);
    end
  endtask

  task automatic reset_mid_access();
    i_valid  = 1'b1;
    i_load   = 1'b1;
    i_store  = 1'b0;
    i_funct3 = 3'b010;
    i_addr   = 32'h0000_4000;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_load  = 1'b0;
    check_eq("rst_acc1_req", 32'(o_mem_req), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_acc2_req", 32'(o_mem_req), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    last_rdata = 32'd0;
    check_eq("rst_req", 32'(o_mem_req), 32'd0);
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_fault", 32'(o_fault), 32'd0);
    check_eq("rst_rdata", o_rdata, 32'd0);
    stray_ack(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        ld;
    logic        st;
    i_rst       = 1'b1;
    i_valid     = 1'b0;
    i_load      = 1'b0;
    i_store     = 1'b0;
    i_funct3    = 3'b000;
    i_addr      = 32'd0;
    i_wdata     = 32'd0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'd0;
    last_rdata  = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    check_eq("reset_ready", 32'(o_ready), 32'd1);
    check_eq("reset_req", 32'(o_mem_req), 32'd0);
    check_eq("reset_done", 32'(o_done), 32'd0);
    check_eq("reset_fault", 32'(o_fault), 32'd0);
    check_eq("reset_rdata", o_rdata, 32'd0);

    // Directed examples.
    run_txn(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1);
    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'd0, 32'h0000_8000, 0);
    check_eq("lb_example", o_rdata, 32'hFFFF_FF80);
    run_txn(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'd0, 32'h0000_8000, 1);
    check_eq("lbu_example", o_rdata, 32'h0000_0080);
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h8001_0000, 2);
    check_eq("lh_example", o_rdata, 32'hFFFF_8001);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'd0, 32'hDEAD_BEEF, 0);
    check_eq("lw_example", o_rdata, 32'hDEAD_BEEF);
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h1234_5678, 32'h0, 0);
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_3003, 32'd0, 32'h7F00_1234, 1);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'h1111_2222, 10);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_5004, 32'd0, 32'h3333_4444, T - 1);
    check_eq("ack_on_timeout", o_rdata, 32'h3333_4444);
    run_txn(1'b0, 1'b1, 3'b001, 32'h0000_6002, 32'hCAFE_F00D, 32'h0, 20);
    run_txn(1'b1, 1'b0, 3'b011, 32'h0000_7000, 32'd0, 32'h0, 0);
    run_txn(1'b1, 1'b0, 3'b110, 32'h0000_7000, 32'd0, 32'h0, 0);
    run_txn(1'b0, 1'b1, 3'b100, 32'h0000_7000, 32'h55, 32'h0, 0);
    run_txn(1'b1, 1'b1, 3'b000, 32'h0000_7001, 32'h66, 32'hFFFF_FFFF, 0);
    run_txn(1'b0, 1'b0, 3'b000, 32'h0000_7000, 32'h77, 32'h0, 0);
    stray_ack(2);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      ld   = 1'($urandom_range(0, 1));
      st   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2)) | (ld && !st ? 3'($urandom_range(0, 1) << 2) : 3'd0);
      run_txn(ld, st, f3, addr, $urandom, $urandom, $urandom_range(0, T + 1));
      if ($urandom_range(0, 7) == 0) stray_ack(1);
    end

    reset_mid_access();
    run_txn(1'b1, 1'b0, 3'b101, 32'h0000_8002, 32'd0, 32'hABCD_0123, 1);
    check_eq("lhu_after_reset", o_rdata, 32'h0000_ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
